// File: rtl/apb_master_bridge_mslv.sv
// APB4 master bridge: queued requests issued as SETUP/ACCESS transfers to one of NUM_SLAVES slaves.
// Latency: push to rsp_valid is 4 edges plus wait states; back-to-back transfers take 2 cycles each.
// Backpressure: req_ready drops when the request FIFO is full; a slave that never answers times out.
module apb_master_bridge_mslv #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int STRB_W        = DATA_WIDTH / 8
) (
  input  logic                             PCLK,
  input  logic                             PRESETn,
  input  logic                             transfer,
  output logic                             req_ready,
  input  logic                             READ_WRITE,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  input  logic [STRB_W-1:0]                req_strb,
  output logic                             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             busy,
  output logic [NUM_SLAVES-1:0]            PSELx,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [STRB_W-1:0]                PSTRB,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR
);

  localparam int SEL_W = $clog2(NUM_SLAVES);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_W-1:0]     strb;
  } req_t;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  req_t                  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  push, pop, fifo_nempty;
  req_t                  head;

  state_t                state_q, state_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  complete, timeout;

  logic [ADDR_WIDTH-1:0] paddr_q;
  logic                  pwrite_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [STRB_W-1:0]     pstrb_q;

  logic                  rsp_valid_q, rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  logic [SEL_W-1:0]      sel;
  logic                  sel_ready, sel_err;
  logic [DATA_WIDTH-1:0] sel_rdata;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // No push/pop bypass: readiness depends only on the registered count.
  assign req_ready   = (count_q != CNT_W'(FIFO_DEPTH));
  assign push        = transfer && req_ready;
  assign fifo_nempty = (count_q != '0);
  assign head        = fifo_mem[rd_ptr_q];

  // Only the addressed slave's response lines are looked at.
  assign sel       = paddr_q[ADDR_WIDTH-1 -: SEL_W];
  assign sel_ready = PREADY[sel];
  assign sel_err   = PSLVERR[sel];
  assign sel_rdata = PRDATA[sel*DATA_WIDTH +: DATA_WIDTH];

  // Request storage; contents need no reset because the pointers gate validity.
  always_ff @(posedge PCLK) begin
    if (push) begin
      fifo_mem[wr_ptr_q].wr    <= READ_WRITE;
      fifo_mem[wr_ptr_q].addr  <= req_addr;
      fifo_mem[wr_ptr_q].wdata <= req_wdata;
      fifo_mem[wr_ptr_q].strb  <= req_strb;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Next state, pop decision and wait-state timeout counting.
  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    pop      = 1'b0;
    complete = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      IDLE: begin
        if (fifo_nempty) begin
          pop     = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (sel_ready) begin
          complete = 1'b1;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          complete = 1'b1;
          timeout  = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
        if (complete) begin
          pop     = fifo_nempty;
          state_d = fifo_nempty ? SETUP : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (pop) to_cnt_d = '0;
  end

  // State, APB request registers and response registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      to_cnt_q    <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      rsp_valid_q <= complete;
      if (pop) begin
        paddr_q  <= head.addr;
        pwrite_q <= head.wr;
        pwdata_q <= head.wr ? head.wdata : '0;
        pstrb_q  <= head.wr ? head.strb : '0;
      end
      if (complete) begin
        rsp_err_q   <= timeout | sel_err;
        rsp_rdata_q <= (!pwrite_q && !timeout && !sel_err) ? sel_rdata : '0;
      end
    end
  end

  // APB control decode from the registered state.
  always_comb begin
    PSELx = '0;
    if (state_q != IDLE) PSELx[sel] = 1'b1;
  end

  assign PENABLE   = (state_q == ACCESS);
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = (state_q != IDLE) || fifo_nempty;

endmodule
